// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Operand conditioning is done once at start so the datapath only sees magnitudes.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Magnitude of the low w bits of x; the most-negative value maps to 2^(w-1).
  function automatic logic [63:0] abs_w(input logic [63:0] x, input int unsigned w,
                                        input logic is_signed);
    logic [63:0] mask;
    logic [63:0] xm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    if (is_signed && xm[6'(w - 1)]) return (-xm) & mask;
    return xm;
  endfunction

endpackage

// File: rtl/seq_multiplier_p.sv
// Multi-cycle shift-add multiplier (MULT/MULTU) feeding HI/LO; one multiplier bit per clock.
// Operands are latched as magnitudes and the sign is reapplied once in the final cycle.
module seq_multiplier_p
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signedOp,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] data_out_q, data_out_d;

  // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every target gets a default first, so no path through the case infers a latch.
  always_comb begin
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = signedOp & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          mag_a_d = {{WIDTH{1'b0}}, WIDTH'(abs_w(64'(dataA), WIDTH, signedOp))};
          mag_b_d = WIDTH'(abs_w(64'(dataB), WIDTH, signedOp));
          prod_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (mag_b_q[0]) prod_d = prod_q + mag_a_q;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
      end
      FIN: begin
        data_out_d = sign_q ? -prod_q : prod_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    dataOut = data_out_q;
  end

endmodule

// File: tb/tb_seq_multiplier_p.sv
// Self-checking bench for seq_multiplier_p: 32-bit and 8-bit instances against
// a plain-arithmetic product model, plus handshake, abort and throughput checks.
module tb_seq_multiplier_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sop32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] out32;
  logic        start8, sop8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier_p #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signedOp(sop32),
    .dataA(a32), .dataB(b32), .busy(busy32), .done(done32), .dataOut(out32)
  );

  seq_multiplier_p #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signedOp(sop8),
    .dataA(a8), .dataB(b8), .busy(busy8), .done(done8), .dataOut(out8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    return s ? 64'(sa * sb) : ua * ub;
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    return s ? 16'(sa * sb) : ua * ub;
  endfunction

  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    @(negedge clk);
    start32 = 1'b1; sop32 = s; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0;
    check({tag, " busy_after_start"}, busy32, 1);
    n = 0;
    while (!done32 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " product"}, out32, ref32(s, a, b));
    check({tag, " busy_in_done"}, busy32, 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, done32, 0);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input string tag);
    int n;
    @(negedge clk);
    start8 = 1'b1; sop8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency8"}, n, 9);
    check({tag, " product8"}, 64'(out8), 64'(ref8(s, a, b)));
    check({tag, " busy8_in_done"}, busy8, 0);
  endtask

  initial begin
    int pulses, bad, n;
    logic [63:0] val;
    int t[$];

    reset = 1'b0;
    start32 = 1'b0; sop32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sop8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy32, 0);
    check("reset done", done32, 0);
    check("reset dataOut", out32, 0);
    check("reset dataOut8", 64'(out8), 0);
    reset = 1'b1;

    op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_max");
    check("u_max literal", out32, 64'hFFFF_FFFE_0000_0001);
    op32(1'b1, 32'hFFFF_FFFD, 32'd7, "s_m3x7");
    check("s_m3x7 literal", out32, 64'hFFFF_FFFF_FFFF_FFEB);
    op32(1'b1, 32'h8000_0000, 32'h8000_0000, "s_minxmin");
    check("s_minxmin literal", out32, 64'h4000_0000_0000_0000);
    op32(1'b0, 32'h8000_0000, 32'h8000_0000, "u_minxmin");
    op32(1'b1, 32'h8000_0000, 32'h0000_0001, "s_minx1");
    check("s_minx1 literal", out32, 64'hFFFF_FFFF_8000_0000);
    op32(1'b1, 32'h0, 32'hFFFF_FFFF, "s_zero");
    op32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, "s_maxxmin");
    for (int i = 0; i < 16; i++)
      op32(1'($urandom_range(0, 1)), $urandom, $urandom, $sformatf("rnd32_%0d", i));

    // A second start mid-run must be ignored.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b0; a32 = 32'd5; b32 = 32'd9;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start32 = 1'b1; sop32 = 1'b1; a32 = 32'hFFFF_FFF0; b32 = 32'd1234;
    @(posedge clk); #1;
    start32 = 1'b0;
    pulses = 0; val = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done32) begin pulses++; val = out32; end
    end
    check("midrun pulses", pulses, 1);
    check("midrun product", val, 64'd45);

    // Synchronous reset at cycle 10 of a run aborts it.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b0; a32 = 32'd1000; b32 = 32'd1000;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort busy", busy32, 0);
    check("abort done", done32, 0);
    check("abort dataOut", out32, 0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done32) pulses++;
    end
    check("abort no_done", pulses, 0);
    op32(1'b0, 32'd12345, 32'd678, "after_abort");

    // start held high: one result per W+2 cycles, stable output between pulses.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b0; a32 = 32'd2; b32 = 32'd3;
    bad = 0;
    for (int c = 0; c < 3 * 34 + 40; c++) begin
      @(posedge clk); #1;
      if (done32) t.push_back(c);
      if (t.size() > 0 && out32 !== 64'd6) bad++;
    end
    start32 = 1'b0;
    check("held pulses_ge3", 64'(t.size() >= 3), 1);
    if (t.size() >= 3) begin
      check("held spacing1", t[1] - t[0], 34);
      check("held spacing2", t[2] - t[1], 34);
    end
    check("held stable", bad, 0);
    n = 0;
    while (busy32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held drain", busy32, 0);

    op8(1'b1, 8'h80, 8'h7F, "w8_s_minxmax");
    check("w8_s_minxmax literal", 64'(out8), 64'hC080);
    op8(1'b0, 8'hFF, 8'hFF, "w8_u_max");
    check("w8_u_max literal", 64'(out8), 64'hFE01);
    op8(1'b1, 8'h80, 8'h80, "w8_s_minxmin");
    for (int i = 0; i < 10; i++)
      op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $sformatf("rnd8_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
